rx_loader: RTL and testbench
============================

// Module: rx_loader
// PURPOSE
//   Write side of the rx operand bank. Loads one N-bit operand into rx1, rx2 or rx3 over a narrow W-bit valid/ready stream.
//   The slot is taken from in_slot on the first beat; the operand arrives LSB-first in BEATS=N/W beats.
//   rx1..rx3 feed the operand-select mux of the modmul pipeline.
//   Per-slot loaded flags tell the pipeline which operands are complete. Per-slot lock inputs stall writes into operands in use.
// PARAMETERS
//   N      1<<16   operand width; N%W==0 required
//   W      64      stream beat width; W<=N
//   BEATS  N/W     beats per operand (localparam); beat counter width max(1,$clog2(BEATS))
// PORTS
//   clk       in   1    clock; all state updates on rising edge
//   rst       in   1    synchronous, active-high reset
//   in_valid  in   1    beat valid
//   in_ready  out  1    beat ready (combinational)
//   in_slot   in   2    target slot, sampled on the first beat only: 0=none (sink), 1=rx1, 2=rx2, 3=rx3
//   in_data   in   W    beat payload
//   lock      in   3    lock[i]=1: slot i+1 must not be written
//   clr       in   3    clr[i]=1: clear loaded[i] (consumer has taken operand i+1)
//   busy      out  1    1 while a multi-beat load is in progress
//   loaded    out  3    loaded[i]=1: rx(i+1) holds a complete operand
//   rx1,rx2,rx3 out N   operand registers
//   in_last   in   1    [RX_LOADER_LAST_CHECK_EN only] producer marks final beat
//   err       out  1    [RX_LOADER_LAST_CHECK_EN only] sticky framing error
// BEHAVIOUR
//   - Handshake:
//     - A beat transfers when in_valid & in_ready at a rising edge.
//     - Producer holds in_valid/in_slot/in_data stable until accepted.
//     - in_ready may depend on in_slot. in_valid must not depend on in_ready.
//   - Reset: state=IDLE, cnt=0, cur_slot=0, rx1=rx2=rx3=0, loaded=3'b000, busy=0, err=0.
//     - in_ready=0 while rst=1.
//   - in_ready:
//     - IDLE: in_slot==0 ? 1 : !lock[in_slot-1]
//     - LOAD: cur_slot==0 ? 1 : !lock[cur_slot-1]
//   - IDLE, beat accepted:
//     - cur_slot<=in_slot; write beat 0 to bits [W-1:0] of the target slot.
//     - loaded[cur_slot-1]<=0.
//     - If BEATS==1: complete in the same edge. Otherwise cnt<=1, go to LOAD, busy=1.
//   - LOAD, beat accepted:
//     - Write in_data to bits [cnt*W +: W] of the target slot; cnt<=cnt+1.
//     - On beat BEATS-1: loaded[cur_slot-1]<=1, cnt<=0, go to IDLE.
//     - in_slot is ignored during LOAD.
//   - Slot 0: beats are accepted and discarded. No register or loaded bit changes. Counting and framing still apply.
//   - Latency:
//     - Each beat is visible on rx* the cycle after acceptance.
//     - loaded rises the cycle after the final beat.
//     - Back-to-back loads need no bubble: IDLE accepts the next first beat in the cycle after completion.
//   - clr vs completion, same slot, same edge: completion wins (loaded=1).
//     - clr for other slots applies normally.
//     - clr of the slot being loaded is a no-op (its loaded bit is already 0).
//   - lock asserted mid-load: stall with cnt held and no write; resume on release. Lock has no effect on slots not being written.
//   - A partially written slot shows mixed old/new data on rx*. Consumers must gate on loaded.
//   - rst mid-load: full reset as above. The partial operand is discarded (register zeroed); the next accepted beat is beat 0.
// CONFIGURATION
//   - RX_LOADER_LAST_CHECK_EN defined: in_last/err ports exist.
//     - in_last=1 on a beat other than BEATS-1: abort. Go to IDLE, cnt<=0, loaded bit stays 0, err<=1.
//     - in_last=0 on beat BEATS-1: load completes normally, err<=1.
//     - err clears only on rst.
//   - Undefined: ports absent; framing by count only.
// STRUCTURE
//   - Shared package modmul_pkg:
//     - SLOT_NONE=2'd0, SLOT_RX1=2'd1, SLOT_RX2=2'd2, SLOT_RX3=2'd3. This is the same encoding the rx select mux uses.
//     - Loader state encodings ST_IDLE/ST_LOAD.
//   - Sub-module rx_slot_reg #(N,W): one N-bit register with beat-indexed write (we, idx, data, rst). Instantiated 3x.
//   - Top keeps the FSM, counter, loaded/err flags and ready logic.
// TESTING  (N=256, W=64, BEATS=4)
//   1. Hold rst for 2 cycles -> rx1..3=0, loaded=000, busy=0, in_ready=0 during reset. in_ready=1 the cycle after release.
//   2. Slot 2, beats 0x11..11,0x22..22,0x33..33,0x44..44 -> rx2={44..,33..,22..,11..}, loaded=010 one cycle after beat 4, rx1/rx3 unchanged.
//   3. Slot 0, 4 beats -> all accepted, rx*/loaded unchanged, busy drops after beat 4.
//   4. Slot 1 load with lock=001 raised after beat 1 for 3 cycles -> in_ready=0, cnt held. Release -> remaining 3 beats complete, loaded[0]=1.
//   5. loaded=111; clr=011 on the edge of the final slot-1 beat -> loaded=101.
//   6. rst after 2 beats into slot 3 -> rx3=0, loaded=000. A new 4-beat load to slot 3 lands intact from beat 0.
//   7. [macro] in_last on beat 2 of a slot-1 load -> err=1, busy=0, loaded[0]=0. err stays 1 until rst.

Source files
------------

// File: rtl/modmul_pkg.sv
`default_nettype none
// ============================================================================
// Module      : modmul_pkg
// Description : Shared types for the modmul operand path: slot encoding used
//               by the rx select mux, loader state encoding, small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package modmul_pkg;

    typedef logic [1:0] slot_t;

    localparam slot_t SLOT_NONE = 2'd0;
    localparam slot_t SLOT_RX1  = 2'd1;
    localparam slot_t SLOT_RX2  = 2'd2;
    localparam slot_t SLOT_RX3  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } ld_state_t;

    function automatic int cnt_width(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

    // Bit i set selects rx(i+1); SLOT_NONE maps to no bits so it never matches lock/loaded.
    function automatic logic [2:0] slot_onehot(input slot_t s);
        logic [2:0] oh;
        oh = 3'b000;
        case (s)
            SLOT_RX1: oh = 3'b001;
            SLOT_RX2: oh = 3'b010;
            SLOT_RX3: oh = 3'b100;
            default:  oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rx_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : rx_loader_if
// Description : Narrow valid/ready operand stream into the rx operand bank.
//               in_last exists only when RX_LOADER_LAST_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface rx_loader_if
    import modmul_pkg::*;
#(
    parameter int W = 64
) ();
    logic         in_valid;
    logic         in_ready;
    slot_t        in_slot;
    logic [W-1:0] in_data;
`ifdef RX_LOADER_LAST_CHECK_EN
    logic         in_last;
`endif

    modport master (
        output in_valid,
        output in_slot,
        output in_data,
`ifdef RX_LOADER_LAST_CHECK_EN
        output in_last,
`endif
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_slot,
        input  in_data,
`ifdef RX_LOADER_LAST_CHECK_EN
        input  in_last,
`endif
        output in_ready
    );
endinterface
`default_nettype wire

// File: rtl/rx_slot_reg.sv
`default_nettype none
// ============================================================================
// Module      : rx_slot_reg
// Description : One N-bit operand register written W bits at a time at a
//               beat index; cleared by synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_slot_reg
    import modmul_pkg::*;
#(
    parameter int N = 1 << 16,
    parameter int W = 64,
    localparam int BEATS = N / W,
    localparam int CW    = cnt_width(BEATS)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          we,
    input  wire logic [CW-1:0] idx,
    input  wire logic [W-1:0]  data,
    output logic      [N-1:0]  q
);

    logic [N-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (we) begin
            for (int b = 0; b < BEATS; b++) begin
                if (idx == CW'(b)) begin
                    r_q[b*W +: W] <= data;
                end
            end
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/rx_loader.sv
`default_nettype none
// ============================================================================
// Module      : rx_loader
// Description : Write side of the rx operand bank. Assembles an N-bit operand
//               from BEATS=N/W LSB-first beats into rx1/rx2/rx3, tracks per-slot
//               loaded flags and honours per-slot write locks.
//               Optional framing check: define RX_LOADER_LAST_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_loader
    import modmul_pkg::*;
#(
    parameter int N = 1 << 16,
    parameter int W = 64
) (
    input  wire logic         clk,
    input  wire logic         rst,
    rx_loader_if.slave        rx_in,
    input  wire logic [2:0]   lock,
    input  wire logic [2:0]   clr,
    output logic              busy,
    output logic      [2:0]   loaded,
    output logic      [N-1:0] rx1,
    output logic      [N-1:0] rx2,
    output logic      [N-1:0] rx3
`ifdef RX_LOADER_LAST_CHECK_EN
    ,
    output logic              err
`endif
);

    localparam int BEATS = N / W;
    localparam int CW    = cnt_width(BEATS);
    localparam logic [CW-1:0] c_last = CW'(BEATS - 1);

    ld_state_t     r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    slot_t         r_cur_slot, w_cur_slot_nxt;
    logic [2:0]    r_loaded, w_loaded_nxt;

    slot_t         w_slot;
    logic [2:0]    w_oh;
    logic [CW-1:0] w_idx;
    logic          w_ready;
    logic          w_acc;
    logic          w_final;
    logic          w_abort;
    logic [N-1:0]  w_rx [3];

    // In IDLE the target comes straight from the stream; during LOAD it is the latched slot.
    always_comb begin
        w_slot  = (r_state == ST_IDLE) ? rx_in.in_slot : r_cur_slot;
        w_oh    = slot_onehot(w_slot);
        w_idx   = (r_state == ST_IDLE) ? '0 : r_cnt;
        w_ready = !rst && ((w_oh & lock) == 3'b000);
        w_acc   = rx_in.in_valid && w_ready;
        w_final = (w_idx == c_last);
    end

    assign rx_in.in_ready = w_ready;

`ifdef RX_LOADER_LAST_CHECK_EN
    logic w_last;
    logic r_err;

    assign w_last  = rx_in.in_last;
    assign w_abort = w_acc && w_last && !w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_acc && (w_last != w_final)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign w_abort = 1'b0;
`endif

    // Completion is applied after clr so that it wins for the slot being finished.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_slot_nxt = r_cur_slot;
        w_loaded_nxt   = r_loaded & ~clr;
        if (w_acc) begin
            if (r_state == ST_IDLE) begin
                w_cur_slot_nxt = rx_in.in_slot;
                w_loaded_nxt   = w_loaded_nxt & ~w_oh;
            end
            if (w_final) begin
                w_loaded_nxt = w_loaded_nxt | w_oh;
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = '0;
            end else if (w_abort) begin
                w_state_nxt  = ST_IDLE;
                w_cnt_nxt    = '0;
            end else begin
                w_state_nxt  = ST_LOAD;
                w_cnt_nxt    = w_idx + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_cur_slot <= SLOT_NONE;
            r_loaded   <= 3'b000;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_slot <= w_cur_slot_nxt;
            r_loaded   <= w_loaded_nxt;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_slot
        rx_slot_reg #(
            .N (N),
            .W (W)
        ) u_slot (
            .clk  (clk),
            .rst  (rst),
            .we   (w_acc && w_oh[i]),
            .idx  (w_idx),
            .data (rx_in.in_data),
            .q    (w_rx[i])
        );
    end

    assign rx1    = w_rx[0];
    assign rx2    = w_rx[1];
    assign rx3    = w_rx[2];
    assign busy   = (r_state == ST_LOAD);
    assign loaded = r_loaded;

endmodule
`default_nettype wire

// File: tb/tb_rx_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_loader
// Description : Self-checking bench for rx_loader (N=256, W=64) against a
//               beat-level reference model of the operand bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_loader;
    import modmul_pkg::*;

    localparam int N     = 256;
    localparam int W     = 64;
    localparam int BEATS = N / W;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   lock;
    logic [2:0]   clr;
    logic         busy;
    logic [2:0]   loaded;
    logic [N-1:0] rx1, rx2, rx3;
`ifdef RX_LOADER_LAST_CHECK_EN
    logic         err;
`endif

    rx_loader_if #(.W(W)) bus ();

    rx_loader #(
        .N (N),
        .W (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx_in  (bus),
        .lock   (lock),
        .clr    (clr),
        .busy   (busy),
        .loaded (loaded),
        .rx1    (rx1),
        .rx2    (rx2),
        .rx3    (rx3)
`ifdef RX_LOADER_LAST_CHECK_EN
        ,
        .err    (err)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: operand bank seen as three N-bit words plus a beat position.
    logic [N-1:0] m_rx [3];
    logic [2:0]   m_loaded;
    bit           m_busy;
    int           m_cnt;
    int           m_slot;
    bit           m_err;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_rx[i] = '0;
        m_loaded = 3'b000;
        m_busy   = 1'b0;
        m_cnt    = 0;
        m_slot   = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_accept(input int slot, input logic [W-1:0] d, input bit last,
                                input logic [2:0] clr_s);
        int s;
        int idx;
        bit fin;
        idx = m_busy ? m_cnt : 0;
        s   = m_busy ? m_slot : slot;
        m_loaded = m_loaded & ~clr_s;
        if (!m_busy) begin
            m_slot = slot;
            if (s != 0) m_loaded[s-1] = 1'b0;
        end
        if (s != 0) m_rx[s-1][idx*W +: W] = d;
        fin = (idx == BEATS - 1);
`ifdef RX_LOADER_LAST_CHECK_EN
        if (last != fin) m_err = 1'b1;
        if (last && !fin) begin
            m_busy = 1'b0;
            m_cnt  = 0;
            return;
        end
`endif
        if (fin) begin
            if (s != 0) m_loaded[s-1] = 1'b1;
            m_busy = 1'b0;
            m_cnt  = 0;
        end else begin
            m_busy = 1'b1;
            m_cnt  = idx + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_rx1"},    rx1,    m_rx[0]);
        chk({tag, "_rx2"},    rx2,    m_rx[1]);
        chk({tag, "_rx3"},    rx3,    m_rx[2]);
        chk({tag, "_loaded"}, N'(loaded), N'(m_loaded));
        chk({tag, "_busy"},   N'(busy),   N'(m_busy));
`ifdef RX_LOADER_LAST_CHECK_EN
        chk({tag, "_err"},    N'(err),    N'(m_err));
`endif
    endtask

    // Present one beat (called just after a rising edge), wait for acceptance, then check.
    task automatic beat(input string tag, input int slot, input logic [W-1:0] d, input bit last);
        int n;
        logic [2:0] clr_s;
        bus.in_valid = 1'b1;
        bus.in_slot  = slot_t'(slot);
        bus.in_data  = d;
`ifdef RX_LOADER_LAST_CHECK_EN
        bus.in_last  = last;
`endif
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_accept"}, N'(bus.in_ready), N'(1'b1));
        clr_s = clr;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        if (n < 50) begin
            model_accept(slot, d, last, clr_s);
            check_all(tag);
        end
    endtask

    task automatic load4(input string tag, input int slot, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input logic [W-1:0] d2, input logic [W-1:0] d3);
        beat(tag, slot, d0, 1'b0);
        beat(tag, slot, d1, 1'b0);
        beat(tag, slot, d2, 1'b0);
        beat(tag, slot, d3, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        logic [W-1:0] d0, d1, d2, d3;

        rst          = 1'b1;
        lock         = 3'b000;
        clr          = 3'b000;
        bus.in_valid = 1'b0;
        bus.in_slot  = SLOT_NONE;
        bus.in_data  = '0;
`ifdef RX_LOADER_LAST_CHECK_EN
        bus.in_last  = 1'b0;
`endif
        model_reset();

        // 1. reset
        repeat (2) begin
            @(negedge clk);
            chk("rst_ready", N'(bus.in_ready), N'(1'b0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all("reset");
        @(negedge clk);
        chk("post_rst_ready", N'(bus.in_ready), N'(1'b1));
        @(posedge clk);
        #1;

        // 2. slot 2 directed load
        load4("t2", 2, {8{8'h11}}, {8{8'h22}}, {8{8'h33}}, {8{8'h44}});
        chk("t2_rx2_const", rx2, {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});
        chk("t2_loaded_const", N'(loaded), N'(3'b010));

        // 3. slot 0 sink
        load4("t3", 0, rnd64(), rnd64(), rnd64(), rnd64());
        chk("t3_busy_const", N'(busy), N'(1'b0));

        // 4. slot 1 with lock stall after the first beat
        d0 = rnd64(); d1 = rnd64(); d2 = rnd64(); d3 = rnd64();
        beat("t4", 1, d0, 1'b0);
        lock         = 3'b001;
        bus.in_valid = 1'b1;
        bus.in_slot  = SLOT_RX1;
        bus.in_data  = d1;
        repeat (3) begin
            @(negedge clk);
            chk("t4_stall_ready", N'(bus.in_ready), N'(1'b0));
            chk("t4_stall_busy",  N'(busy), N'(1'b1));
            @(posedge clk);
            #1;
        end
        check_all("t4_stall");
        lock = 3'b000;
        beat("t4", 1, d1, 1'b0);
        beat("t4", 1, d2, 1'b0);
        beat("t4", 1, d3, 1'b1);
        chk("t4_rx1_const", rx1, {d3, d2, d1, d0});
        chk("t4_loaded_const", N'(loaded), N'(3'b011));

        // Fill slot 3 so all three are loaded, then reload slot 1 with clr on its last beat
        load4("t5a", 3, rnd64(), rnd64(), rnd64(), rnd64());
        chk("t5_all_loaded", N'(loaded), N'(3'b111));
        beat("t5", 1, rnd64(), 1'b0);
        beat("t5", 2, rnd64(), 1'b0);
        beat("t5", 3, rnd64(), 1'b0);
        clr = 3'b011;
        beat("t5", 0, rnd64(), 1'b1);
        clr = 3'b000;
        chk("t5_loaded_const", N'(loaded), N'(3'b101));

        // 6. reset in the middle of a slot-3 load
        beat("t6", 3, rnd64(), 1'b0);
        beat("t6", 3, rnd64(), 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("t6_rx3_zero", rx3, '0);
        chk("t6_loaded_zero", N'(loaded), N'(3'b000));
        check_all("t6_rst");
        d0 = rnd64(); d1 = rnd64(); d2 = rnd64(); d3 = rnd64();
        load4("t6b", 3, d0, d1, d2, d3);
        chk("t6_rx3_const", rx3, {d3, d2, d1, d0});

        // Randomised loads: random target, random in_slot noise on later beats, random gaps
        for (int l = 0; l < 16; l++) begin
            int sl;
            sl = int'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            for (int k = 0; k < BEATS; k++) begin
                beat("rnd", (k == 0) ? sl : int'($urandom_range(0, 3)), rnd64(), k == BEATS - 1);
            end
        end

`ifdef RX_LOADER_LAST_CHECK_EN
        // 7. early in_last aborts a slot-1 load and sets sticky err
        beat("t7", 1, rnd64(), 1'b0);
        beat("t7", 1, rnd64(), 1'b0);
        beat("t7", 1, rnd64(), 1'b1);
        chk("t7_err",    N'(err),       N'(1'b1));
        chk("t7_busy",   N'(busy),      N'(1'b0));
        chk("t7_loaded", N'(loaded[0]), N'(1'b0));
        load4("t7b", 2, rnd64(), rnd64(), rnd64(), rnd64());
        chk("t7_err_sticky", N'(err), N'(1'b1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("t7_err_rst", N'(err), N'(1'b0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
